// File: rtl/mem_stream_reader_if.sv
// Valid/ready word stream between the memory reader and its consumer.
interface mem_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/mem_stream_reader.sv
// Walks an address window of a synchronous-read memory and streams each word out
// through a 2-entry buffer that covers the one-cycle read latency under backpressure.
module mem_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] r_data,
    mem_stream_reader_if.master   strm
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued_q, issued_d;
    logic [ADDR_WIDTH:0]   accepted_q, accepted_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, wr_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  done_q, done_d;
    logic                  load;
    logic                  push;
    logic                  pop;
    logic                  issue;

    assign strm.m_valid = (count_q != 2'd0);
    assign strm.m_data  = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : '0;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign r_addr       = r_addr_q;

    // The word in flight lands in the buffer the cycle after its address was presented.
    assign push = inflight_q;
    assign pop  = strm.m_valid & strm.m_ready;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        r_addr_d   = r_addr_q;
        issued_d   = issued_q;
        accepted_d = accepted_q + {{ADDR_WIDTH{1'b0}}, pop};
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        inflight_d = 1'b0;
        done_d     = 1'b0;
        load       = 1'b0;
        issue      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        load       = 1'b1;
                        state_d    = RUN;
                        r_addr_d   = base_addr;
                        issued_d   = '0;
                        accepted_d = '0;
                    end
                end
            end
            RUN: begin
                // Occupancy after this edge plus the new read must fit the buffer.
                issue = (issued_q < len_q) && (count_d < 2'd2);
                if (issue) begin
                    inflight_d = 1'b1;
                    issued_d   = issued_q + 1'b1;
                    if (issued_q + 1'b1 < len_q) begin
                        r_addr_d = r_addr_q + 1'b1;
                    end else begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!inflight_q && (accepted_d == len_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            r_addr_q   <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_addr_q   <= r_addr_d;
            len_q      <= load ? length : len_q;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_q ^ pop;
            wr_ptr_q   <= wr_ptr_q ^ push;
            done_q     <= done_d;
        end
    end

    // NOTE: buffer storage is not reset; m_data is masked to zero whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= r_data;
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: a queue-based stream model checked every
// cycle, plus literal expectations pinning latency, wrap and stall behaviour.
module tb_mem_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic       busy;
    logic       done;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] mem [256];

    mem_stream_reader_if #(.DATA_WIDTH(8)) strm ();

    mem_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .r_addr    (r_addr),
        .r_data    (r_data),
        .strm      (strm.master)
    );

    always #5 clk = ~clk;

    // Synchronous memory with one-cycle registered read.
    always @(posedge clk) r_data <= mem[r_addr];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Model: words still owed to the consumer, transfer-active flag, expected done pulse.
    logic [7:0] exp_q [$];
    logic       active   = 1'b0;
    logic       exp_done = 1'b0;
    int         hs_cnt   = 0;
    logic [7:0] last_data = 8'h00;
    logic       hs_w;
    logic       start_ok;

    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, active});
        check("done", {31'd0, done}, {31'd0, exp_done});
        if (exp_q.size() == 0)
            check("m_valid_unexpected", {31'd0, strm.m_valid}, 32'd0);
        else if (strm.m_valid)
            check("m_data", {24'd0, strm.m_data}, {24'd0, exp_q[0]});

        hs_w = strm.m_valid && strm.m_ready;
        if (rst) begin
            exp_q.delete();
            active   = 1'b0;
            exp_done = 1'b0;
        end else begin
            start_ok = start && !active;
            exp_done = 1'b0;
            if (hs_w && exp_q.size() > 0) begin
                last_data = exp_q.pop_front();
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    active   = 1'b0;
                    exp_done = 1'b1;
                end
            end
            if (start_ok) begin
                if (length == 9'd0) begin
                    exp_done = 1'b1;
                end else begin
                    active = 1'b1;
                    for (int i = 0; i < int'(length); i++)
                        exp_q.push_back(mem[8'(int'(base_addr) + i)]);
                end
            end
        end
    end

    // Returns 1 ns after the edge at which start is sampled (E0).
    task automatic start_xfer(input logic [7:0] b, input logic [8:0] l);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        length    = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic expect_beat(input string name, input logic v, input logic [7:0] d);
        @(negedge clk);
        check({name, "_valid"}, {31'd0, strm.m_valid}, {31'd0, v});
        if (v) check({name, "_data"}, {24'd0, strm.m_data}, {24'd0, d});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    int         hs0;
    logic       seen;
    logic [7:0] prev_addr;
    logic [5:0] pat;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h10);
        rst          = 1'b1;
        start        = 1'b0;
        base_addr    = 8'h00;
        length       = 9'd0;
        strm.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", {31'd0, strm.m_valid}, 32'd0);
        check("rst_m_data", {24'd0, strm.m_data}, 32'd0);
        check("rst_r_addr", {24'd0, r_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic transfer, consumer always ready: beats after E2, E3, E4; done after E5.
        strm.m_ready = 1'b1;
        start_xfer(8'h04, 9'd3);
        @(negedge clk);
        check("t1_r_addr_first", {24'd0, r_addr}, 32'h04);
        check("t1_valid_e0", {31'd0, strm.m_valid}, 32'd0);
        expect_beat("t1_e1", 1'b0, 8'h00);
        expect_beat("t1_e2", 1'b1, 8'h14);
        expect_beat("t1_e3", 1'b1, 8'h15);
        expect_beat("t1_e4", 1'b1, 8'h16);
        @(negedge clk);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_valid_after", {31'd0, strm.m_valid}, 32'd0);

        // Same transfer with toggling ready.
        pat = 6'b101001;
        hs0 = hs_cnt;
        start_xfer(8'h04, 9'd3);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            strm.m_ready = pat[k % 6];
            @(negedge clk);
            seen = done;
            @(posedge clk);
            #1;
        end
        check("t2_done_seen", {31'd0, seen}, 32'd1);
        check("t2_beats", hs_cnt - hs0, 32'd3);
        check("t2_last", {24'd0, last_data}, 32'h16);

        // Address wrap.
        strm.m_ready = 1'b1;
        hs0 = hs_cnt;
        start_xfer(8'hFE, 9'd4);
        @(negedge clk); check("t3_addr0", {24'd0, r_addr}, 32'hFE);
        @(negedge clk); check("t3_addr1", {24'd0, r_addr}, 32'hFF);
        @(negedge clk); check("t3_addr2", {24'd0, r_addr}, 32'h00);
        @(negedge clk); check("t3_addr3", {24'd0, r_addr}, 32'h01);
        wait_done(20, "t3_done_seen");
        check("t3_beats", hs_cnt - hs0, 32'd4);
        check("t3_last", {24'd0, last_data}, 32'h11);

        // Zero length: done next cycle, no beats, address untouched.
        @(negedge clk);
        prev_addr = r_addr;
        hs0 = hs_cnt;
        start_xfer(8'h55, 9'd0);
        @(negedge clk);
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_r_addr", {24'd0, r_addr}, {24'd0, prev_addr});
        @(negedge clk);
        check("t4_done_low", {31'd0, done}, 32'd0);
        check("t4_beats", hs_cnt - hs0, 32'd0);

        // Long stall: only two reads outstanding, head word held; a start while busy is ignored.
        strm.m_ready = 1'b0;
        hs0 = hs_cnt;
        start_xfer(8'h04, 9'd5);
        repeat (8) @(posedge clk);
        #1 start = 1'b1; base_addr = 8'h40; length = 9'd2;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t5_valid", {31'd0, strm.m_valid}, 32'd1);
        check("t5_data", {24'd0, strm.m_data}, 32'h14);
        check("t5_r_addr", {24'd0, r_addr}, 32'h06);
        @(posedge clk);
        #1 strm.m_ready = 1'b1;
        wait_done(30, "t5_done_seen");
        check("t5_beats", hs_cnt - hs0, 32'd5);
        check("t5_last", {24'd0, last_data}, 32'h18);

        // Reset mid-transfer, then a fresh one-word transfer.
        hs0 = hs_cnt;
        start_xfer(8'h04, 9'd5);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (hs_cnt - hs0 >= 2) break;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_valid", {31'd0, strm.m_valid}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        hs0 = hs_cnt;
        start_xfer(8'h00, 9'd1);
        wait_done(20, "t6_done_seen");
        check("t6_beats", hs_cnt - hs0, 32'd1);
        check("t6_data", {24'd0, last_data}, 32'h10);

        // Whole memory in one transfer.
        hs0 = hs_cnt;
        start_xfer(8'h80, 9'd256);
        wait_done(300, "t7_done_seen");
        check("t7_beats", hs_cnt - hs0, 32'd256);
        check("t7_last", {24'd0, last_data}, 32'h8F);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
